// File: rtl/i2c_ad2_responder.sv
// I2C target emulating a PmodAD2 (AD7991-style) ADC: config-byte writes, 2-byte conversion reads.
// Optional macro STALE_FLAG_EN: bit 7 of the high byte reports the stale-sample flag.
module i2c_ad2_responder #(
    parameter logic [6:0]  I2C_ADDR       = 7'h28,
    parameter int unsigned SYNC_STAGES    = 2,
    parameter logic [7:0]  DEFAULT_CONFIG = 8'h10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        scl,
    input  logic        sda_i,
    output logic        sda_o,
    output logic        sda_oe,
    input  logic [11:0] s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    output logic [7:0]  config_out,
    output logic        config_wr,
    output logic [3:0]  state_out
);
    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        ADDR     = 4'd1,
        ADDR_ACK = 4'd2,
        WR_DATA  = 4'd3,
        WR_ACK   = 4'd4,
        RD_DATA  = 4'd5,
        RD_ACK   = 4'd6,
        IGNORE   = 4'd7
    } state_e;

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
    logic                   scl_prev_q, scl_prev_d, sda_prev_q, sda_prev_d;
    logic [3:0]             cnt_q, cnt_d;
    logic [7:0]             shift_q, shift_d;
    logic [15:0]            word_q, word_d;
    logic                   byte_sel_q, byte_sel_d;
    logic                   sda_oe_q, sda_oe_d;
    logic [7:0]             cfg_q, cfg_d;
    logic                   cfg_wr_q, cfg_wr_d;
    logic [11:0]            hold_q, hold_d;
    logic                   tready_q, tready_d;
    logic                   scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;
    logic                   handshake, snap, stale_bit;
    logic [1:0]             ch;
    logic [15:0]            snap_word;
    logic [7:0]             tx_byte;

`ifdef STALE_FLAG_EN
    logic stale_q, stale_d;
    assign stale_bit = stale_q;
`else
    assign stale_bit = 1'b0;
`endif

    assign scl_s     = scl_sync_q[SYNC_STAGES-1];
    assign sda_s     = sda_sync_q[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_prev_q;
    assign scl_fall  = ~scl_s & scl_prev_q;
    assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
    assign handshake = s_axis_tvalid & tready_q;

    // Channel number is the lowest enabled channel bit, 0 when none is set
    always_comb begin
        ch = 2'd0;
        if (cfg_q[4])      ch = 2'd0;
        else if (cfg_q[5]) ch = 2'd1;
        else if (cfg_q[6]) ch = 2'd2;
        else if (cfg_q[7]) ch = 2'd3;
    end

    assign snap_word = {stale_bit, 1'b0, ch, hold_q};
    assign tx_byte   = byte_sel_q ? word_q[7:0] : word_q[15:8];

    always_comb begin
        state_d    = state_q;
        scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl};
        sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_i};
        scl_prev_d = scl_s;
        sda_prev_d = sda_s;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        word_d     = word_q;
        byte_sel_d = byte_sel_q;
        sda_oe_d   = sda_oe_q;
        cfg_d      = cfg_q;
        cfg_wr_d   = 1'b0;
        hold_d     = hold_q;
        tready_d   = 1'b1;
        snap       = 1'b0;

        if (handshake) hold_d = s_axis_tdata;

        if (start_det) begin
            state_d  = ADDR;
            cnt_d    = 4'd0;
            sda_oe_d = 1'b0;
        end else if (stop_det) begin
            state_d  = IDLE;
            sda_oe_d = 1'b0;
        end else if (scl_rise) begin
            if (state_q == ADDR || state_q == WR_DATA || state_q == RD_ACK)
                shift_d = {shift_q[6:0], sda_s};
            if (state_q == ADDR || state_q == WR_DATA || state_q == RD_DATA)
                cnt_d = cnt_q + 4'd1;
        end else if (scl_fall) begin
            // SDA is only ever changed here, during the SCL-low phase
            unique case (state_q)
                ADDR: if (cnt_q == 4'd8) begin
                    if (shift_q[7:1] == I2C_ADDR) begin
                        state_d  = ADDR_ACK;
                        sda_oe_d = 1'b1;
                    end else begin
                        state_d  = IGNORE;
                    end
                end
                ADDR_ACK: begin
                    cnt_d = 4'd0;
                    if (shift_q[0]) begin
                        snap       = 1'b1;
                        byte_sel_d = 1'b0;
                        state_d    = RD_DATA;
                        sda_oe_d   = ~snap_word[15];
                    end else begin
                        state_d  = WR_DATA;
                        sda_oe_d = 1'b0;
                    end
                end
                WR_DATA: if (cnt_q == 4'd8) begin
                    state_d  = WR_ACK;
                    sda_oe_d = 1'b1;
                    cfg_d    = shift_q;
                    cfg_wr_d = 1'b1;
                end
                WR_ACK: begin
                    state_d  = WR_DATA;
                    cnt_d    = 4'd0;
                    sda_oe_d = 1'b0;
                end
                RD_DATA: begin
                    if (cnt_q == 4'd8) begin
                        state_d  = RD_ACK;
                        sda_oe_d = 1'b0;
                    end else begin
                        sda_oe_d = ~tx_byte[3'd7 - cnt_q[2:0]];
                    end
                end
                RD_ACK: begin
                    cnt_d = 4'd0;
                    if (shift_q[0]) begin
                        state_d = IGNORE;
                    end else if (!byte_sel_q) begin
                        state_d    = RD_DATA;
                        byte_sel_d = 1'b1;
                        sda_oe_d   = ~word_q[7];
                    end else begin
                        snap       = 1'b1;
                        state_d    = RD_DATA;
                        byte_sel_d = 1'b0;
                        sda_oe_d   = ~snap_word[15];
                    end
                end
                default: sda_oe_d = 1'b0;
            endcase
        end

        if (snap) word_d = snap_word;
`ifdef STALE_FLAG_EN
        // A sample accepted in the snapshot cycle is not in the word, so it wins
        stale_d = stale_q;
        if (snap)      stale_d = 1'b1;
        if (handshake) stale_d = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
            cnt_q      <= 4'd0;
            shift_q    <= 8'd0;
            word_q     <= 16'd0;
            byte_sel_q <= 1'b0;
            sda_oe_q   <= 1'b0;
            cfg_q      <= DEFAULT_CONFIG;
            cfg_wr_q   <= 1'b0;
            hold_q     <= 12'd0;
            tready_q   <= 1'b0;
`ifdef STALE_FLAG_EN
            stale_q    <= 1'b1;
`endif
        end else begin
            state_q    <= state_d;
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
            scl_prev_q <= scl_prev_d;
            sda_prev_q <= sda_prev_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            word_q     <= word_d;
            byte_sel_q <= byte_sel_d;
            sda_oe_q   <= sda_oe_d;
            cfg_q      <= cfg_d;
            cfg_wr_q   <= cfg_wr_d;
            hold_q     <= hold_d;
            tready_q   <= tready_d;
`ifdef STALE_FLAG_EN
            stale_q    <= stale_d;
`endif
        end
    end

    assign sda_o         = 1'b0;
    assign sda_oe        = sda_oe_q;
    assign s_axis_tready = tready_q;
    assign config_out    = cfg_q;
    assign config_wr     = cfg_wr_q;
    assign state_out     = state_q;
endmodule

// File: tb/tb_i2c_ad2_responder.sv
// Bench for i2c_ad2_responder: bit-banged I2C master plus a transaction-level ADC model.
module tb_i2c_ad2_responder;
    localparam int unsigned Q        = 10;
    localparam logic [3:0]  IDLE_ENC = 4'd0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        scl = 1'b1;
    logic        sda_m = 1'b1;
    logic        sda_i;
    logic        sda_o, sda_oe, s_axis_tready, config_wr;
    logic [11:0] s_axis_tdata = 12'd0;
    logic        s_axis_tvalid = 1'b0;
    logic [7:0]  config_out;
    logic [3:0]  state_out;

    int checks = 0;
    int failures = 0;
    int wr_pulses = 0;
    int exp_wr = 0;
    int viol = 0;
    logic oe_seen = 1'b0;
    logic oe_prev = 1'b0;

    logic [11:0] m_hold = 12'd0;
    logic        m_stale = 1'b1;
    logic [7:0]  m_cfg = 8'h10;
    logic [7:0]  last_hi, last_lo;

    assign sda_i = sda_m & ~sda_oe;

    always #10 clk = ~clk;

    i2c_ad2_responder dut (
        .clk(clk), .rst_n(rst_n), .scl(scl), .sda_i(sda_i), .sda_o(sda_o), .sda_oe(sda_oe),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .config_out(config_out), .config_wr(config_wr), .state_out(state_out)
    );

    always @(negedge clk) begin
        if (config_wr) wr_pulses++;
        if (sda_oe) oe_seen = 1'b1;
        if (sda_oe !== oe_prev && scl) viol++;
        oe_prev = sda_oe;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic waitq();
        repeat (Q) @(negedge clk);
    endtask

    task automatic load_sample(input logic [11:0] v);
        @(negedge clk);
        s_axis_tdata  = v;
        s_axis_tvalid = 1'b1;
        @(negedge clk);
        s_axis_tvalid = 1'b0;
        m_hold  = v;
        m_stale = 1'b0;
    endtask

    // Reference word: channel from lowest enabled config bit, stale flag optional
    task automatic snapshot_word(output logic [15:0] w);
        logic [1:0] chn;
        logic       st;
        chn = 2'd0;
        for (int i = 3; i >= 0; i--) if (m_cfg[4+i]) chn = 2'(i);
`ifdef STALE_FLAG_EN
        st = m_stale;
`else
        st = 1'b0;
`endif
        w = {st, 1'b0, chn, m_hold};
        m_stale = 1'b1;
    endtask

    task automatic i2c_start();
        waitq(); sda_m = 1'b1;
        waitq(); scl = 1'b1;
        waitq(); sda_m = 1'b0;
        waitq(); scl = 1'b0;
    endtask

    task automatic i2c_stop();
        waitq(); sda_m = 1'b0;
        waitq(); scl = 1'b1;
        waitq(); sda_m = 1'b1;
        waitq();
    endtask

    task automatic clock_bit(input logic b, output logic r);
        waitq(); sda_m = b;
        waitq(); scl = 1'b1;
        waitq(); r = sda_i;
        waitq(); scl = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) clock_bit(d[i], r);
        clock_bit(1'b1, r);
        ack = ~r;
    endtask

    task automatic recv_byte(input logic mack, input logic do_load, input logic [11:0] lv,
                             output logic [7:0] d);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            clock_bit(1'b1, r);
            d[i] = r;
            if (do_load && i == 4) load_sample(lv);
        end
        clock_bit(~mack, r);
    endtask

    task automatic read_words(input int n, input logic mid_load, input logic [11:0] lv);
        logic [15:0] w;
        logic [7:0]  hi, lo;
        for (int k = 0; k < n; k++) begin
            snapshot_word(w);
            recv_byte(1'b1, 1'b0, 12'd0, hi);
            check("rd_hi", 32'(hi), 32'(w[15:8]));
            recv_byte(k < n - 1, mid_load && k == 0, lv, lo);
            check("rd_lo", 32'(lo), 32'(w[7:0]));
            last_hi = hi;
            last_lo = lo;
        end
    endtask

    task automatic write_cfg(input logic [7:0] c);
        logic ack;
        i2c_start();
        send_byte(8'h50, ack);
        check("wr_addr_ack", 32'(ack), 32'd1);
        send_byte(c, ack);
        check("wr_data_ack", 32'(ack), 32'd1);
        m_cfg = c;
        exp_wr++;
        i2c_stop();
    endtask

    initial begin
        logic ack, r;
        logic [7:0] tmp;
        int nwr, nw;

        repeat (3) @(negedge clk);
        check("rst_oe", 32'(sda_oe), 32'd0);
        check("rst_sda_o", 32'(sda_o), 32'd0);
        check("rst_cfg", 32'(config_out), 32'h10);
        check("rst_cfg_wr", 32'(config_wr), 32'd0);
        check("rst_state", 32'(state_out), 32'(IDLE_ENC));
        check("rst_tready", 32'(s_axis_tready), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("tready_up", 32'(s_axis_tready), 32'd1);

        // Single configuration write
        wr_pulses = 0; exp_wr = 0;
        write_cfg(8'h20);
        check("cfg_pulses", 32'(wr_pulses), 32'd1);
        check("cfg_val", 32'(config_out), 32'h20);
        check("idle_after_stop", 32'(state_out), 32'(IDLE_ENC));

        // Read with ACK then NACK
        load_sample(12'hABC);
        write_cfg(8'h10);
        i2c_start();
        send_byte(8'h51, ack);
        check("rd_addr_ack", 32'(ack), 32'd1);
        read_words(1, 1'b0, 12'd0);
        check("abc_hi", 32'(last_hi), 32'h0A);
        check("abc_lo", 32'(last_lo), 32'hBC);
        waitq();
        check("nack_release", 32'(sda_oe), 32'd0);
        i2c_stop();
        check("nack_idle", 32'(state_out), 32'(IDLE_ENC));

        // Two-word read, channel 2
        write_cfg(8'h40);
        load_sample(12'h123);
        i2c_start();
        send_byte(8'h51, ack);
        check("rd2_addr_ack", 32'(ack), 32'd1);
        read_words(2, 1'b0, 12'd0);
        i2c_stop();
        check("two_lo", 32'(last_lo), 32'h23);

        // Wrong address is ignored until the next START
        oe_seen = 1'b0; wr_pulses = 0; exp_wr = 0;
        i2c_start();
        send_byte(8'h52, ack);
        check("bad_addr_nack", 32'(ack), 32'd0);
        send_byte(8'h00, ack);
        check("bad_oe_never", 32'(oe_seen), 32'd0);
        check("bad_no_wr", 32'(wr_pulses), 32'd0);
        i2c_start();
        send_byte(8'h50, ack);
        check("recover_ack", 32'(ack), 32'd1);
        send_byte(8'h30, ack);
        m_cfg = 8'h30; exp_wr++;
        i2c_stop();
        check("recover_cfg", 32'(config_out), 32'h30);

        // Repeated START write->read; sample changes mid low byte
        i2c_start();
        send_byte(8'h50, ack);
        send_byte(8'h40, ack);
        m_cfg = 8'h40; exp_wr++;
        i2c_start();
        send_byte(8'h51, ack);
        check("rs_addr_ack", 32'(ack), 32'd1);
        read_words(2, 1'b1, 12'h456);
        i2c_stop();
        check("rs_new_lo", 32'(last_lo), 32'h56);

        // Randomised config writes and reads
        for (int it = 0; it < 6; it++) begin
            nwr = $urandom_range(1, 2);
            i2c_start();
            send_byte(8'h50, ack);
            for (int k = 0; k < nwr; k++) begin
                tmp = 8'($urandom);
                send_byte(tmp, ack);
                check("rnd_wr_ack", 32'(ack), 32'd1);
                m_cfg = tmp; exp_wr++;
            end
            i2c_stop();
            check("rnd_cfg", 32'(config_out), 32'(m_cfg));
            if ($urandom_range(0, 1) == 1) load_sample(12'($urandom));
            nw = $urandom_range(1, 3);
            i2c_start();
            send_byte(8'h51, ack);
            read_words(nw, 1'($urandom_range(0, 1)), 12'($urandom));
            i2c_stop();
        end
        check("wr_pulse_total", 32'(wr_pulses), 32'(exp_wr));

        // Asynchronous reset in the middle of a read
        i2c_start();
        send_byte(8'h51, ack);
        waitq();
        if (!sda_oe) begin
            clock_bit(1'b1, r);
            waitq();
        end
        check("oe_before_rst", 32'(sda_oe), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_async_oe", 32'(sda_oe), 32'd0);
        check("rst_async_state", 32'(state_out), 32'(IDLE_ENC));
        m_cfg = 8'h10; m_hold = 12'd0; m_stale = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("cfg_after_rst", 32'(config_out), 32'h10);
        i2c_stop();
        check("idle_after_rst", 32'(state_out), 32'(IDLE_ENC));
        check("sda_scl_low_only", 32'(viol), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
